// File: rtl/if_fetch_unit.sv
// MIPS32 IF stage: owns the PC, one outstanding ROM fetch, IF/ID register one cycle after the transfer.
// Stall parks a returned word in a one-entry skid and drops rom_req; flush drains an in-flight fetch.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_rdata,
  output logic        id_valid,
  output logic [31:0] id_addr,
  output logic [31:0] id_inst
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SKID  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        armed_q;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_addr_q, id_addr_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] skid_addr_q, skid_addr_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] drain_tgt_q, drain_tgt_d;

  logic        xfer;
  logic        br_take;
  logic [31:0] ds_addr;

  // armed_q holds off the first request until one cycle after reset releases
  assign rom_req  = armed_q && (state_q != ST_SKID);
  assign rom_addr = pc_q;
  assign id_valid = id_valid_q;
  assign id_addr  = id_addr_q;
  assign id_inst  = id_inst_q;

  assign xfer    = rom_req && rom_ack;
  assign br_take = id_valid_q && branch_flag && !stall && !flush;
  assign ds_addr = id_addr_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_valid_d  = id_valid_q;
    id_addr_d   = id_addr_q;
    id_inst_d   = id_inst_q;
    skid_addr_d = skid_addr_q;
    skid_inst_d = skid_inst_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    drain_tgt_d = drain_tgt_q;

    if (flush) begin
      id_valid_d = 1'b0;
      pend_d     = 1'b0;
      state_d    = ST_RUN;
      if (rom_req && !rom_ack) begin
        state_d     = ST_DRAIN;
        drain_tgt_d = flush_pc;
      end else begin
        pc_d = flush_pc;
      end
    end else begin
      case (state_q)
        ST_DRAIN: begin
          if (xfer) begin
            pc_d    = drain_tgt_q;
            state_d = ST_RUN;
          end
        end
        ST_SKID: begin
          if (!stall) begin
            id_valid_d = 1'b1;
            id_addr_d  = skid_addr_q;
            id_inst_d  = skid_inst_q;
            state_d    = ST_RUN;
          end
        end
        default: begin
          if (xfer) begin
            pc_d   = pend_q ? pend_tgt_q : pc_q + PC_STEP;
            pend_d = 1'b0;
            if (!stall) begin
              id_valid_d = 1'b1;
              id_addr_d  = pc_q;
              id_inst_d  = rom_rdata;
            end else begin
              skid_addr_d = pc_q;
              skid_inst_d = rom_rdata;
              state_d     = ST_SKID;
            end
          end else if (!stall) begin
            id_valid_d = 1'b0;
          end
        end
      endcase

      // Delay slot still to be fetched: redirect after it; otherwise it is already captured.
      if (br_take) begin
        if (pc_q == ds_addr && !xfer) begin
          pend_d     = 1'b1;
          pend_tgt_d = branch_addr;
        end else begin
          pc_d = branch_addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      armed_q     <= 1'b0;
      pc_q        <= RESET_PC;
      id_valid_q  <= 1'b0;
      id_addr_q   <= 32'd0;
      id_inst_q   <= 32'd0;
      skid_addr_q <= 32'd0;
      skid_inst_q <= 32'd0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'd0;
      drain_tgt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      pc_q        <= pc_d;
      id_valid_q  <= id_valid_d;
      id_addr_q   <= id_addr_d;
      id_inst_q   <= id_inst_d;
      skid_addr_q <= skid_addr_d;
      skid_inst_q <= skid_inst_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      drain_tgt_q <= drain_tgt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle expected bus and IF/ID values.
module tb_if_fetch_unit;

  localparam logic [31:0] A = 32'hBFC0_0000;
  localparam logic [31:0] K = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_flag, rom_req, rom_ack, id_valid;
  logic [31:0] flush_pc, branch_addr, rom_addr, rom_rdata, id_addr, id_inst;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM content is a fixed function of the address so delivered words are traceable
  assign rom_rdata = rom_addr ^ K;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_flag(branch_flag), .branch_addr(branch_addr),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_rdata(rom_rdata),
    .id_valid(id_valid), .id_addr(id_addr), .id_inst(id_inst)
  );

  typedef struct {
    logic        st;
    logic        ak;
    logic        fl;
    logic [31:0] fpc;
    logic        bf;
    logic [31:0] ba;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ida;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic st, input logic ak,
                      input logic fl, input logic [31:0] fpc, input logic bf,
                      input logic [31:0] ba, input logic e_req, input logic [31:0] e_addr,
                      input logic e_vld, input logic [31:0] e_ida);
    @(negedge clk);
    rst = r; stall = st; rom_ack = ak; flush = fl; flush_pc = fpc;
    branch_flag = bf; branch_addr = ba;
    #1;
    chk({tag, " rom_req"}, {31'd0, rom_req}, {31'd0, e_req});
    chk({tag, " rom_addr"}, rom_addr, e_addr);
    chk({tag, " id_valid"}, {31'd0, id_valid}, {31'd0, e_vld});
    chk({tag, " id_addr"}, id_addr, e_ida);
    if (e_vld) chk({tag, " id_inst"}, id_inst, e_ida ^ K);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; rom_ack = 1'b0; flush = 1'b0; flush_pc = 32'd0;
    branch_flag = 1'b0; branch_addr = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, " rom_req"}, {31'd0, rom_req}, 32'd0);
    chk({tag, " rom_addr"}, rom_addr, A);
    chk({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, " id_addr"}, id_addr, 32'd0);
    chk({tag, " id_inst"}, id_inst, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rom_ack = 1'b0; flush = 1'b0; flush_pc = 32'd0;
    branch_flag = 1'b0; branch_addr = 32'd0;

    // stall, ack, flush, flush_pc, branch, target | req, rom_addr, id_valid, id_addr
    tbl[0]  = '{0, 1, 0, 32'd0, 0, 32'd0,       0, A,          0, 32'd0};
    tbl[1]  = '{0, 1, 0, 32'd0, 0, 32'd0,       1, A,          0, 32'd0};
    tbl[2]  = '{0, 1, 0, 32'd0, 0, 32'd0,       1, A + 32'h4,  1, A};
    tbl[3]  = '{0, 1, 0, 32'd0, 0, 32'd0,       1, A + 32'h8,  1, A + 32'h4};
    tbl[4]  = '{1, 1, 0, 32'd0, 0, 32'd0,       1, A + 32'hC,  1, A + 32'h8};
    tbl[5]  = '{1, 1, 0, 32'd0, 0, 32'd0,       0, A + 32'h10, 1, A + 32'h8};
    tbl[6]  = '{1, 1, 0, 32'd0, 0, 32'd0,       0, A + 32'h10, 1, A + 32'h8};
    tbl[7]  = '{0, 1, 0, 32'd0, 0, 32'd0,       0, A + 32'h10, 1, A + 32'h8};
    tbl[8]  = '{0, 1, 0, 32'd0, 0, 32'd0,       1, A + 32'h10, 1, A + 32'hC};
    tbl[9]  = '{0, 0, 0, 32'd0, 1, A + 32'h100, 1, A + 32'h14, 1, A + 32'h10};
    tbl[10] = '{0, 0, 0, 32'd0, 0, 32'd0,       1, A + 32'h14, 0, A + 32'h10};
    tbl[11] = '{0, 1, 0, 32'd0, 0, 32'd0,       1, A + 32'h14, 0, A + 32'h10};
    tbl[12] = '{0, 1, 0, 32'd0, 0, 32'd0,       1, A + 32'h100, 1, A + 32'h14};
    tbl[13] = '{0, 0, 0, 32'd0, 0, 32'd0,       1, A + 32'h104, 1, A + 32'h100};
    tbl[14] = '{0, 1, 0, 32'd0, 0, 32'd0,       1, A + 32'h104, 0, A + 32'h100};

    do_reset("reset0");
    for (int i = 0; i < 15; i++) begin
      step($sformatf("tbl%0d", i), 1'b0, tbl[i].st, tbl[i].ak, tbl[i].fl, tbl[i].fpc,
           tbl[i].bf, tbl[i].ba, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_ida);
    end

    // Branch whose delay slot is parked in the skid: pc jumps directly
    do_reset("reset1");
    step("skb0", 0, 0, 1, 0, 0, 0, 0,          0, A,          0, 0);
    step("skb1", 0, 0, 1, 0, 0, 0, 0,          1, A,          0, 0);
    step("skb2", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h4,  1, A);
    step("skb3", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h8,  1, A + 32'h4);
    step("skb4", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'hC,  1, A + 32'h8);
    step("skb5", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h10, 1, A + 32'hC);
    step("skb6", 0, 1, 1, 0, 0, 1, A + 32'h100, 1, A + 32'h14, 1, A + 32'h10);
    step("skb7", 0, 0, 0, 0, 0, 1, A + 32'h100, 0, A + 32'h18, 1, A + 32'h10);
    step("skb8", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h100, 1, A + 32'h14);

    // Flush with fetch outstanding -> drain, retarget during drain, PC wrap
    step("fl0", 0, 0, 0, 1, A + 32'h380, 0, 0, 1, A + 32'h104, 1, A + 32'h100);
    step("fl1", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h104, 0, A + 32'h100);
    step("fl2", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h380, 0, A + 32'h100);
    step("fl3", 0, 0, 0, 1, A + 32'h200, 0, 0, 1, A + 32'h384, 1, A + 32'h380);
    step("fl4", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, A + 32'h384, 0, A + 32'h380);
    step("fl5", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h384, 0, A + 32'h380);
    step("fl6", 0, 0, 1, 0, 0, 0, 0,          1, 32'hFFFF_FFFC, 0, A + 32'h380);
    step("fl7", 0, 0, 1, 0, 0, 0, 0,          1, 32'h0, 1, 32'hFFFF_FFFC);
    step("fl8", 0, 0, 1, 1, A + 32'h380, 0, 0, 1, 32'h4, 1, 32'h0);

    // Reset mid-request with flush and branch asserted
    step("rs0", 1, 0, 0, 1, A + 32'h200, 1, A + 32'h100, 1, A + 32'h380, 0, 32'h0);
    step("rs1", 0, 0, 1, 0, 0, 0, 0,          0, A,         0, 32'h0);
    chk("rs1 id_inst", id_inst, 32'd0);
    step("rs2", 0, 0, 1, 0, 0, 0, 0,          1, A,         0, 32'h0);
    step("rs3", 0, 0, 1, 0, 0, 0, 0,          1, A + 32'h4, 1, A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
